adc_deserializer: RTL and testbench

Parametrised serial-to-parallel front end for the ADC bit stream. Assembles DATA_W-bit samples from a one-bit serial input, qualified by a bit-enable and framed by a start-of-frame strobe. Tags each sample with its channel index in a round-robin of CHANNELS. Presents samples on a valid/ready output register feeding the downstream sample FIFO/packetiser, with overrun and framing-error reporting.

---
 rtl/adc_pkg.sv | 17 +
 rtl/adc_deser_outreg.sv | 44 ++++
 rtl/adc_deserializer.sv | 141 ++++++++++++++
 tb/tb_adc_deserializer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC serial deserializer and the downstream packetiser.
package adc_pkg;

    localparam int unsigned ADC_DATA_W   = 12;
    localparam int unsigned ADC_CHANNELS = 4;

    typedef enum logic {
        ST_HUNT  = 1'b0,
        ST_SHIFT = 1'b1
    } adc_state_e;

    // Channel index width: clog2 with a floor of one bit.
    function automatic int unsigned adc_cw(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_deser_outreg.sv
// One-entry valid/ready holding register: loads completed samples, drops them and
// flags a sticky overrun when the held sample has not yet been accepted.
module adc_deser_outreg #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    input  logic         clr,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         overrun
);

    logic accept_c;
    logic drop_c;

    assign accept_c = valid && ready;
    assign drop_c   = load && valid && !ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load && (!valid || ready)) begin
                dout  <= din;
                valid <= 1'b1;
            end else if (accept_c) begin
                valid <= 1'b0;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop_c) begin
                overrun <= 1'b1;
            end else if (clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_deserializer.sv
// Serial-to-parallel ADC front end with frame sync and round-robin channel tagging.
// Define ADC_DESER_PARITY_EN to append an even-parity bit to every sample word.
module adc_deserializer
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W    = ADC_DATA_W,
    parameter int unsigned CHANNELS  = ADC_CHANNELS,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in,
    input  logic                          bit_en,
    input  logic                          frame,
    output logic [DATA_W-1:0]             out_data,
    output logic [adc_cw(CHANNELS)-1:0]   out_chan,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overrun,
    output logic                          sync_err,
    output logic                          parity_err,
    input  logic                          clr_flags
);

    localparam int unsigned CW = adc_cw(CHANNELS);
`ifdef ADC_DESER_PARITY_EN
    localparam int unsigned WL = DATA_W + 1;
`else
    localparam int unsigned WL = DATA_W;
`endif
    localparam int unsigned BCW = $clog2(WL + 1);
    localparam int unsigned OW  = DATA_W + CW;

    adc_state_e        state, state_nxt;
    logic [DATA_W-1:0] sreg, sreg_nxt;
    logic [DATA_W-1:0] shifted, loaded, sample_c;
    logic [BCW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [CW-1:0]     chan_cnt, chan_cnt_nxt;
    logic              done_c;
    logic              sync_err_nxt;
    logic              parity_err_nxt;
    logic [OW-1:0]     held;

    // Shift-in value for a continuing sample and load value for bit 0 of a new frame.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted = {sreg[DATA_W-2:0], in};
            loaded  = {{(DATA_W-1){1'b0}}, in};
        end else begin
            shifted = {in, sreg[DATA_W-1:1]};
            loaded  = {in, {(DATA_W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_HUNT;
            sreg       <= '0;
            bit_cnt    <= '0;
            chan_cnt   <= '0;
            sync_err   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            sreg       <= sreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            chan_cnt   <= chan_cnt_nxt;
            sync_err   <= sync_err_nxt;
            parity_err <= parity_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sreg_nxt       = sreg;
        bit_cnt_nxt    = bit_cnt;
        chan_cnt_nxt   = chan_cnt;
        done_c         = 1'b0;
        sync_err_nxt   = 1'b0;
        parity_err_nxt = 1'b0;
        sample_c       = shifted;
        case (state)
            ST_HUNT: begin
                if (bit_en && frame) begin
                    state_nxt    = ST_SHIFT;
                    sreg_nxt     = loaded;
                    bit_cnt_nxt  = BCW'(1);
                    chan_cnt_nxt = '0;
                end
            end
            ST_SHIFT: begin
                if (bit_en) begin
                    if (frame && ((bit_cnt != '0) || (chan_cnt != '0))) begin
                        // Misplaced frame: abandon the partial word and resync.
                        sync_err_nxt = 1'b1;
                        sreg_nxt     = loaded;
                        bit_cnt_nxt  = BCW'(1);
                        chan_cnt_nxt = '0;
                    end else begin
`ifdef ADC_DESER_PARITY_EN
                        sample_c = sreg;
                        if (bit_cnt < BCW'(DATA_W)) begin
                            sreg_nxt = shifted;
                        end else begin
                            parity_err_nxt = (in != ^sreg);
                        end
`else
                        sreg_nxt = shifted;
`endif
                        if (bit_cnt == BCW'(WL - 1)) begin
                            done_c       = 1'b1;
                            bit_cnt_nxt  = '0;
                            chan_cnt_nxt = (chan_cnt == CW'(CHANNELS - 1)) ? '0 : chan_cnt + 1'b1;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    adc_deser_outreg #(
        .W (OW)
    ) u_outreg (
        .clk     (clk),
        .rst     (rst),
        .load    (done_c),
        .din     ({sample_c, chan_cnt}),
        .ready   (out_ready),
        .clr     (clr_flags),
        .dout    (held),
        .valid   (out_valid),
        .overrun (overrun)
    );

    assign out_data = held[OW-1:CW];
    assign out_chan = held[CW-1:0];

endmodule

// File: tb/tb_adc_deserializer.sv
// Directed self-checking bench for adc_deserializer (DATA_W=4, CHANNELS=2), MSB- and LSB-first.
module tb_adc_deserializer;

    logic       clk;
    logic       rst;
    logic       in;
    logic       bit_en;
    logic       frame;
    logic       out_ready;
    logic       clr_flags;
    logic [3:0] out_data;
    logic [0:0] out_chan;
    logic       out_valid;
    logic       overrun;
    logic       sync_err;
    logic       parity_err;
    logic [3:0] lsb_data;
    logic [0:0] lsb_chan;
    logic       lsb_valid;
    logic       lsb_overrun;
    logic       lsb_sync_err;
    logic       lsb_parity_err;

    int checks   = 0;
    int failures = 0;

    adc_deserializer #(.DATA_W(4), .CHANNELS(2), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .in(in), .bit_en(bit_en), .frame(frame),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .sync_err(sync_err), .parity_err(parity_err), .clr_flags(clr_flags)
    );

    adc_deserializer #(.DATA_W(4), .CHANNELS(2), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .in(in), .bit_en(bit_en), .frame(frame),
        .out_data(lsb_data), .out_chan(lsb_chan), .out_valid(lsb_valid), .out_ready(out_ready),
        .overrun(lsb_overrun), .sync_err(lsb_sync_err), .parity_err(lsb_parity_err),
        .clr_flags(clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs; returns 1 time unit after the consuming edge.
    task automatic clk_in(input logic b, input logic en, input logic f);
        in = b; bit_en = en; frame = f;
        @(posedge clk);
        #1;
    endtask

    // Serial word w[3] first; frame optional on the first bit; correct parity appended if enabled.
    task automatic send_word(input logic [3:0] w, input logic f);
        for (int i = 3; i >= 0; i--) clk_in(w[i], 1'b1, (i == 3) && f);
`ifdef ADC_DESER_PARITY_EN
        clk_in(^w, 1'b1, 1'b0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clk_in(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; clr_flags = 1'b0;
        clk_in(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checks++; if (out_data !== 4'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (out_chan !== 1'b0) begin failures++; $display("FAIL reset_chan got=%b exp=0", out_chan); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL reset_sync_err got=%b exp=0", sync_err); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
    endtask

    task automatic test_bit_order();
        do_reset();
        for (int i = 3; i >= 1; i--) begin
            clk_in(i == 3 ? 1'b1 : (i == 2 ? 1'b0 : 1'b1), 1'b1, i == 3);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL order_early_valid bit=%0d got=%b exp=0", 3 - i, out_valid); end
        end
        clk_in(1'b1, 1'b1, 1'b0);
`ifdef ADC_DESER_PARITY_EN
        clk_in(1'b1, 1'b1, 1'b0);
`endif
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL order_w1_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 4'hB) begin failures++; $display("FAIL order_w1_msb_data got=%h exp=b", out_data); end
        checks++; if (out_chan !== 1'b0) begin failures++; $display("FAIL order_w1_chan got=%b exp=0", out_chan); end
        checks++; if (lsb_data !== 4'hD) begin failures++; $display("FAIL order_w1_lsb_data got=%h exp=d", lsb_data); end
        checks++; if (lsb_chan !== 1'b0) begin failures++; $display("FAIL order_w1_lsb_chan got=%b exp=0", lsb_chan); end
        send_word(4'b0110, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL order_w2_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 4'h6) begin failures++; $display("FAIL order_w2_msb_data got=%h exp=6", out_data); end
        checks++; if (out_chan !== 1'b1) begin failures++; $display("FAIL order_w2_chan got=%b exp=1", out_chan); end
        checks++; if (lsb_data !== 4'h6) begin failures++; $display("FAIL order_w2_lsb_data got=%h exp=6", lsb_data); end
        checks++; if (lsb_chan !== 1'b1) begin failures++; $display("FAIL order_w2_lsb_chan got=%b exp=1", lsb_chan); end
        checks++; if ({overrun, sync_err, parity_err} !== 3'b000) begin failures++; $display("FAIL order_flags got=%b exp=000", {overrun, sync_err, parity_err}); end
        clk_in(1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL order_retire_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_overrun();
        do_reset();
        out_ready = 1'b0;
        send_word(4'b1011, 1'b1);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovr_w1_valid got=%b exp=1", out_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_w1_overrun got=%b exp=0", overrun); end
        send_word(4'b0110, 1'b0);
        checks++; if (out_data !== 4'hB) begin failures++; $display("FAIL ovr_held_data got=%h exp=b", out_data); end
        checks++; if (out_chan !== 1'b0) begin failures++; $display("FAIL ovr_held_chan got=%b exp=0", out_chan); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        clr_flags = 1'b1;
        send_word(4'b0011, 1'b0);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
        checks++; if (out_data !== 4'hB) begin failures++; $display("FAIL ovr_held_data2 got=%h exp=b", out_data); end
        clk_in(1'b0, 1'b0, 1'b0);
        clr_flags = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovr_still_valid got=%b exp=1", out_valid); end
        out_ready = 1'b1;
        clk_in(1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovr_retire got=%b exp=0", out_valid); end
    endtask

    task automatic test_sync_err();
        do_reset();
        send_word(4'b1011, 1'b1);
        checks++; if (out_data !== 4'hB || out_valid !== 1'b1) begin failures++; $display("FAIL sync_w1 got=%h/%b exp=b/1", out_data, out_valid); end
        clk_in(1'b0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sync_accept got=%b exp=0", out_valid); end
        clk_in(1'b1, 1'b1, 1'b0);
        clk_in(1'b1, 1'b1, 1'b1);
        checks++; if (sync_err !== 1'b1) begin failures++; $display("FAIL sync_pulse got=%b exp=1", sync_err); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sync_no_partial got=%b exp=0", out_valid); end
        clk_in(1'b0, 1'b1, 1'b0);
        checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL sync_one_cycle got=%b exp=0", sync_err); end
        clk_in(1'b1, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sync_early got=%b exp=0", out_valid); end
        clk_in(1'b1, 1'b1, 1'b0);
`ifdef ADC_DESER_PARITY_EN
        clk_in(1'b1, 1'b1, 1'b0);
`endif
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sync_resume_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 4'hB) begin failures++; $display("FAIL sync_resume_data got=%h exp=b", out_data); end
        checks++; if (out_chan !== 1'b0) begin failures++; $display("FAIL sync_resume_chan got=%b exp=0", out_chan); end
    endtask

    task automatic test_hunt_and_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            clk_in(1'b1, 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hunt_discard bit=%0d got=%b exp=0", i, out_valid); end
        end
        out_ready = 1'b0;
        send_word(4'b1011, 1'b1);
        send_word(4'b0110, 1'b0);
        clk_in(1'b1, 1'b1, 1'b0);
        clk_in(1'b0, 1'b1, 1'b0);
        checks++; if (overrun !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL hunt_pre_rst got=%b/%b exp=1/1", overrun, out_valid); end
        rst = 1'b1;
        clk_in(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        out_ready = 1'b1;
        checks++; if ({out_data, out_chan} !== 5'h00) begin failures++; $display("FAIL rst_data_chan got=%h exp=00", {out_data, out_chan}); end
        checks++; if ({out_valid, overrun, sync_err, parity_err} !== 4'h0) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {out_valid, overrun, sync_err, parity_err}); end
        for (int i = 0; i < 3; i++) begin
            clk_in(1'b1, 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_back_to_hunt bit=%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] words [4];
        words[0] = 4'hB; words[1] = 4'h6; words[2] = 4'h3; words[3] = 4'hC;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send_word(words[k], k == 0);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid k=%0d got=%b exp=1", k, out_valid); end
            checks++; if (out_data !== words[k]) begin failures++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, out_data, words[k]); end
            checks++; if (out_chan !== 1'(k % 2)) begin failures++; $display("FAIL b2b_chan k=%0d got=%b exp=%0d", k, out_chan, k % 2); end
            checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun k=%0d got=%b exp=0", k, overrun); end
        end
    endtask

`ifdef ADC_DESER_PARITY_EN
    task automatic test_parity();
        do_reset();
        clk_in(1'b1, 1'b1, 1'b1);
        clk_in(1'b0, 1'b1, 1'b0);
        clk_in(1'b1, 1'b1, 1'b0);
        clk_in(1'b1, 1'b1, 1'b0);
        clk_in(1'b0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 4'hB) begin failures++; $display("FAIL par_bad_sample got=%b/%h exp=1/b", out_valid, out_data); end
        checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL par_bad_pulse got=%b exp=1", parity_err); end
        clk_in(1'b0, 1'b0, 1'b0);
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_pulse_len got=%b exp=0", parity_err); end
        send_word(4'b0110, 1'b0);
        checks++; if (parity_err !== 1'b0 || out_data !== 4'h6) begin failures++; $display("FAIL par_good6 got=%b/%h exp=0/6", parity_err, out_data); end
        send_word(4'b1011, 1'b0);
        checks++; if (parity_err !== 1'b0 || out_data !== 4'hB) begin failures++; $display("FAIL par_goodB got=%b/%h exp=0/b", parity_err, out_data); end
    endtask
`endif

    initial begin
        in = 1'b0; bit_en = 1'b0; frame = 1'b0; rst = 1'b1; out_ready = 1'b1; clr_flags = 1'b0;
        test_reset();
        test_bit_order();
        test_overrun();
        test_sync_err();
        test_hunt_and_reset();
        test_back_to_back();
`ifdef ADC_DESER_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
